// File: rtl/proc_io_bridge.sv
// proc_io_bridge: bridges an upstream sample stream into per-port input FIFOs
// read by a processor via one-hot strobes, and captures processor results into
// a shared output FIFO tagged with the producing port index.
// Optional feature macro: PROC_IO_BRIDGE_STATUS_EN adds stat_clr/status
// sticky event bits {strobe_err, overflow, underflow}.
module proc_io_bridge #(
  parameter int IW     = 19,
  parameter int OW     = 28,
  parameter int NPORT  = 4,
  parameter int IDEPTH = 4,
  parameter int ODEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IW-1:0]            s_data,
  input  logic [$clog2(NPORT)-1:0] s_port,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [NPORT-1:0]         req_in,
  output logic [IW-1:0]            io_in,
  input  logic [NPORT-1:0]         out_en,
  input  logic [OW-1:0]            io_out,
  output logic [OW-1:0]            m_data,
  output logic [$clog2(NPORT)-1:0] m_port,
  output logic                     m_valid,
  input  logic                     m_ready
`ifdef PROC_IO_BRIDGE_STATUS_EN
  ,
  input  logic                     stat_clr,
  output logic [2:0]               status
`endif
);

  localparam int PW  = $clog2(NPORT);
  localparam int IAW = $clog2(IDEPTH);
  localparam int OAW = $clog2(ODEPTH);

  // Storage (not reset) and wrap-bit pointers
  logic [IW-1:0]    imem [NPORT][IDEPTH];
  logic [IAW:0]     iwp  [NPORT];
  logic [IAW:0]     irp  [NPORT];
  logic [NPORT-1:0] iempty;
  logic [NPORT-1:0] ifull;

  logic [PW+OW-1:0] omem [ODEPTH];
  logic [OAW:0]     owp;
  logic [OAW:0]     orp;
  logic             oempty;
  logic             ofull;

  logic [PW-1:0]    rsel;
  logic [PW-1:0]    wsel;
  logic             push;
  logic             pop;
  logic             cap;
  logic             opop;

  // Lowest set index of a strobe vector; 0 when none set
  function automatic logic [PW-1:0] lowest(input logic [NPORT-1:0] v);
    logic found;
    lowest = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (v[i] && !found) begin
        lowest = PW'(i);
        found  = 1'b1;
      end
    end
  endfunction

  // Per-port full/empty flags from pointer MSB compare
  always_comb begin
    for (int unsigned k = 0; k < NPORT; k++) begin
      iempty[k] = (iwp[k] == irp[k]);
      ifull[k]  = (iwp[k][IAW] != irp[k][IAW]) &&
                  (iwp[k][IAW-1:0] == irp[k][IAW-1:0]);
    end
    oempty = (owp == orp);
    ofull  = (owp[OAW] != orp[OAW]) && (owp[OAW-1:0] == orp[OAW-1:0]);
  end

  // Strobe decode, handshakes and combinational read paths
  always_comb begin
    rsel    = lowest(req_in);
    wsel    = lowest(out_en);
    s_ready = !ifull[s_port];
    push    = s_valid && !ifull[s_port];
    pop     = (|req_in) && !iempty[rsel];
    cap     = (|out_en) && !ofull;
    opop    = !oempty && m_ready;
    io_in   = pop ? imem[rsel][irp[rsel][IAW-1:0]] : '0;
    m_valid = !oempty;
    {m_port, m_data} = oempty ? '0 : omem[orp[OAW-1:0]];
  end

  // FIFO storage writes
  always_ff @(posedge clk) begin
    if (push) imem[s_port][iwp[s_port][IAW-1:0]] <= s_data;
    if (cap)  omem[owp[OAW-1:0]] <= {wsel, io_out};
  end

  // Pointer updates; reset empties every FIFO and ignores strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NPORT; k++) begin
        iwp[k] <= '0;
        irp[k] <= '0;
      end
      owp <= '0;
      orp <= '0;
    end else begin
      for (int unsigned k = 0; k < NPORT; k++) begin
        if (push && s_port == PW'(k)) iwp[k] <= iwp[k] + 1'b1;
        if (pop  && rsel   == PW'(k)) irp[k] <= irp[k] + 1'b1;
      end
      if (cap)  owp <= owp + 1'b1;
      if (opop) orp <= orp + 1'b1;
    end
  end

`ifdef PROC_IO_BRIDGE_STATUS_EN
  logic underflow;
  logic overflow;
  logic strobe_err;

  // Event detection; multi-hot means more than one bit set
  always_comb begin
    underflow  = (|req_in) && iempty[rsel];
    overflow   = (|out_en) && ofull;
    strobe_err = ((req_in & (req_in - 1'b1)) != '0) ||
                 ((out_en & (out_en - 1'b1)) != '0);
  end

  // Sticky status; a new event wins over stat_clr in the same cycle
  always_ff @(posedge clk) begin
    if (rst) status <= '0;
    else     status <= (stat_clr ? 3'b000 : status) | {strobe_err, overflow, underflow};
  end
`endif

endmodule

// File: tb/tb_proc_io_bridge.sv
// Testbench for proc_io_bridge: directed table, overflow sequence, and
// randomized traffic against a queue-based reference model.
module tb_proc_io_bridge;

  localparam int IW = 19, OW = 28, NPORT = 4, IDEPTH = 4, ODEPTH = 8;

  logic          clk;
  logic          rst;
  logic [IW-1:0] s_data;
  logic [1:0]    s_port;
  logic          s_valid;
  logic          s_ready;
  logic [3:0]    req_in;
  logic [IW-1:0] io_in;
  logic [3:0]    out_en;
  logic [OW-1:0] io_out;
  logic [OW-1:0] m_data;
  logic [1:0]    m_port;
  logic          m_valid;
  logic          m_ready;
  logic          stat_clr;
`ifdef PROC_IO_BRIDGE_STATUS_EN
  logic [2:0]    status;
  logic [2:0]    mstat;
`endif

  proc_io_bridge #(.IW(IW), .OW(OW), .NPORT(NPORT), .IDEPTH(IDEPTH), .ODEPTH(ODEPTH)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_port(s_port), .s_valid(s_valid),
    .s_ready(s_ready), .req_in(req_in), .io_in(io_in), .out_en(out_en),
    .io_out(io_out), .m_data(m_data), .m_port(m_port), .m_valid(m_valid),
    .m_ready(m_ready)
`ifdef PROC_IO_BRIDGE_STATUS_EN
    , .stat_clr(stat_clr), .status(status)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst; logic sv; logic [1:0] sp; logic [IW-1:0] sd;
    logic [3:0] req; logic [3:0] oe; logic [OW-1:0] io; logic mr; logic clr;
    logic e_srdy; logic [IW-1:0] e_io; logic e_mv; logic [OW-1:0] e_md; logic [1:0] e_mp;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Reference model: plain queues
  logic [IW-1:0]   iq [NPORT][$];
  logic [OW+1:0]   oq [$];

  function automatic vec_t mk(logic r, logic sv, logic [1:0] sp, logic [IW-1:0] sd,
                              logic [3:0] req, logic [3:0] oe, logic [OW-1:0] io,
                              logic mr, logic clr, logic e_srdy, logic [IW-1:0] e_io,
                              logic e_mv, logic [OW-1:0] e_md, logic [1:0] e_mp);
    vec_t v;
    v.rst = r; v.sv = sv; v.sp = sp; v.sd = sd; v.req = req; v.oe = oe; v.io = io;
    v.mr = mr; v.clr = clr; v.e_srdy = e_srdy; v.e_io = e_io; v.e_mv = e_mv;
    v.e_md = e_md; v.e_mp = e_mp;
    return v;
  endfunction

  function automatic int low(logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic bit multi(logic [3:0] v);
    return $countones(v) > 1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One cycle: drive at negedge, compare before posedge, advance model
  task automatic step(input vec_t v, input bit use_tbl, input string tag);
    logic          x_srdy, x_mv;
    logic [IW-1:0] x_io;
    logic [OW-1:0] x_md;
    logic [1:0]    x_mp;
    int            k, w;
    bit            do_push, do_pop, do_cap, do_opop;
    rst = v.rst; s_valid = v.sv; s_port = v.sp; s_data = v.sd; req_in = v.req;
    out_en = v.oe; io_out = v.io; m_ready = v.mr; stat_clr = v.clr;
    #1;
    k = low(v.req);
    w = low(v.oe);
    if (use_tbl) begin
      x_srdy = v.e_srdy; x_io = v.e_io; x_mv = v.e_mv; x_md = v.e_md; x_mp = v.e_mp;
    end else begin
      x_srdy = iq[v.sp].size() < IDEPTH;
      x_io   = (v.req != 0 && iq[k].size() > 0) ? iq[k][0] : '0;
      x_mv   = oq.size() > 0;
      {x_mp, x_md} = x_mv ? oq[0] : '0;
    end
    chk({tag, ".s_ready"}, 64'(s_ready), 64'(x_srdy));
    chk({tag, ".io_in"},   64'(io_in),   64'(x_io));
    chk({tag, ".m_valid"}, 64'(m_valid), 64'(x_mv));
    chk({tag, ".m_data"},  64'(m_data),  64'(x_md));
    chk({tag, ".m_port"},  64'(m_port),  64'(x_mp));
`ifdef PROC_IO_BRIDGE_STATUS_EN
    chk({tag, ".status"},  64'(status),  64'(mstat));
`endif
    do_push = v.sv && iq[v.sp].size() < IDEPTH;
    do_pop  = v.req != 0 && iq[k].size() > 0;
    do_cap  = v.oe != 0 && oq.size() < ODEPTH;
    do_opop = v.mr && oq.size() > 0;
    if (v.rst) begin
      for (int p = 0; p < NPORT; p++) iq[p].delete();
      oq.delete();
`ifdef PROC_IO_BRIDGE_STATUS_EN
      mstat = '0;
`endif
    end else begin
`ifdef PROC_IO_BRIDGE_STATUS_EN
      mstat = (v.clr ? 3'b000 : mstat) |
              {multi(v.req) || multi(v.oe), v.oe != 0 && oq.size() >= ODEPTH,
               v.req != 0 && iq[k].size() == 0};
`endif
      if (do_pop)  void'(iq[k].pop_front());
      if (do_push) iq[v.sp].push_back(v.sd);
      if (do_opop) void'(oq.pop_front());
      if (do_cap)  oq.push_back({2'(w), v.io});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t tbl [$];
  vec_t rv;

  initial begin
`ifdef PROC_IO_BRIDGE_STATUS_EN
    mstat = '0;
`endif
    rst = 1'b1; s_valid = 0; s_port = 0; s_data = 0; req_in = 0; out_en = 0;
    io_out = 0; m_ready = 0; stat_clr = 0;
    @(posedge clk);
    @(negedge clk);

    //           rst sv sp sd            req      oe       io             mr clr  srdy io_in        mv md             mp
    tbl.push_back(mk(1, 0, 0, 0,          4'b0000, 4'b0000, 0,             0, 0,   1, 0,           0, 0,             0)); // reset state
    tbl.push_back(mk(0, 1, 2, 5,          4'b0000, 4'b0000, 0,             0, 0,   1, 0,           0, 0,             0));
    tbl.push_back(mk(0, 1, 2, 19'(-7),    4'b0000, 4'b0000, 0,             0, 0,   1, 0,           0, 0,             0));
    tbl.push_back(mk(0, 0, 0, 0,          4'b0100, 4'b0000, 0,             0, 0,   1, 5,           0, 0,             0));
    tbl.push_back(mk(0, 0, 0, 0,          4'b0100, 4'b0000, 0,             0, 0,   1, 19'(-7),     0, 0,             0));
    tbl.push_back(mk(0, 0, 0, 0,          4'b0100, 4'b0000, 0,             0, 0,   1, 0,           0, 0,             0)); // underflow
    tbl.push_back(mk(0, 1, 0, 1,          4'b0000, 4'b0000, 0,             0, 0,   1, 0,           0, 0,             0));
    tbl.push_back(mk(0, 1, 0, 2,          4'b0000, 4'b0000, 0,             0, 0,   1, 0,           0, 0,             0));
    tbl.push_back(mk(0, 1, 0, 3,          4'b0000, 4'b0000, 0,             0, 0,   1, 0,           0, 0,             0));
    tbl.push_back(mk(0, 1, 0, 4,          4'b0000, 4'b0000, 0,             0, 0,   1, 0,           0, 0,             0));
    tbl.push_back(mk(0, 0, 0, 0,          4'b0000, 4'b0000, 0,             0, 0,   0, 0,           0, 0,             0)); // port 0 full
    tbl.push_back(mk(0, 0, 1, 0,          4'b0000, 4'b0000, 0,             0, 0,   1, 0,           0, 0,             0)); // port 1 ready
    tbl.push_back(mk(0, 1, 0, 9,          4'b0001, 4'b0000, 0,             0, 0,   0, 1,           0, 0,             0)); // pop+push on full
    tbl.push_back(mk(0, 0, 0, 0,          4'b0001, 4'b0000, 0,             0, 0,   1, 2,           0, 0,             0));
    tbl.push_back(mk(0, 0, 0, 0,          4'b0001, 4'b0000, 0,             0, 0,   1, 3,           0, 0,             0));
    tbl.push_back(mk(0, 0, 0, 0,          4'b0001, 4'b0000, 0,             0, 0,   1, 4,           0, 0,             0));
    tbl.push_back(mk(0, 0, 0, 0,          4'b0001, 4'b0000, 0,             0, 0,   1, 0,           0, 0,             0)); // 9 was refused
    tbl.push_back(mk(0, 0, 0, 0,          4'b0000, 4'b0010, 28'h7FFFFFF,   0, 0,   1, 0,           0, 0,             0));
    tbl.push_back(mk(0, 0, 0, 0,          4'b0000, 4'b0000, 0,             0, 0,   1, 0,           1, 28'h7FFFFFF,   1));
    tbl.push_back(mk(0, 0, 0, 0,          4'b0000, 4'b0000, 0,             0, 0,   1, 0,           1, 28'h7FFFFFF,   1)); // held
    tbl.push_back(mk(0, 0, 0, 0,          4'b0000, 4'b0000, 0,             1, 0,   1, 0,           1, 28'h7FFFFFF,   1));
    tbl.push_back(mk(0, 0, 0, 0,          4'b0000, 4'b0000, 0,             0, 0,   1, 0,           0, 0,             0));
    tbl.push_back(mk(0, 1, 1, 11,         4'b0000, 4'b0000, 0,             0, 0,   1, 0,           0, 0,             0));
    tbl.push_back(mk(0, 1, 3, 33,         4'b0000, 4'b0000, 0,             0, 0,   1, 0,           0, 0,             0));
    tbl.push_back(mk(0, 0, 0, 0,          4'b1010, 4'b0000, 0,             0, 0,   1, 11,          0, 0,             0)); // multi-hot req
    tbl.push_back(mk(0, 0, 0, 0,          4'b1000, 4'b0000, 0,             0, 0,   1, 33,          0, 0,             0));
    tbl.push_back(mk(0, 0, 0, 0,          4'b0010, 4'b0000, 0,             0, 1,   1, 0,           0, 0,             0)); // clr vs underflow
    tbl.push_back(mk(0, 0, 0, 0,          4'b0000, 4'b0000, 0,             0, 1,   1, 0,           0, 0,             0));
    tbl.push_back(mk(0, 1, 0, 1,          4'b0000, 4'b0000, 0,             0, 0,   1, 0,           0, 0,             0));
    tbl.push_back(mk(0, 1, 0, 2,          4'b0000, 4'b0000, 0,             0, 0,   1, 0,           0, 0,             0));
    tbl.push_back(mk(0, 1, 2, 3,          4'b0000, 4'b0000, 0,             0, 0,   1, 0,           0, 0,             0));
    tbl.push_back(mk(0, 0, 0, 0,          4'b0000, 4'b0001, 100,           0, 0,   1, 0,           0, 0,             0));
    tbl.push_back(mk(0, 0, 0, 0,          4'b0000, 4'b0100, 200,           0, 0,   1, 0,           1, 100,           0));
    tbl.push_back(mk(1, 1, 0, 77,         4'b0001, 4'b0001, 9,             0, 0,   1, 1,           1, 100,           0)); // rst with strobes
    tbl.push_back(mk(0, 0, 0, 0,          4'b0001, 4'b0000, 0,             0, 0,   1, 0,           0, 0,             0));
    tbl.push_back(mk(0, 0, 0, 0,          4'b0100, 4'b0000, 0,             0, 0,   1, 0,           0, 0,             0));
    tbl.push_back(mk(0, 0, 0, 0,          4'b0000, 4'b0110, 5,             0, 0,   1, 0,           0, 0,             0)); // multi-hot out_en
    tbl.push_back(mk(0, 0, 0, 0,          4'b0000, 4'b0000, 0,             1, 0,   1, 0,           1, 5,             1));
    tbl.push_back(mk(0, 0, 0, 0,          4'b0000, 4'b0000, 0,             0, 0,   1, 0,           0, 0,             0));

    foreach (tbl[i]) step(tbl[i], 1'b1, $sformatf("tbl%0d", i));

    // Output FIFO overflow: 9 captures with downstream stalled
    for (int i = 0; i < 9; i++)
      step(mk(0, 0, 0, 0, 4'b0000, 4'b0001, 28'(i + 1), 0, 0, 1, 0, i > 0, i > 0 ? 28'd1 : 28'd0, 0),
           1'b1, $sformatf("ovf_cap%0d", i));
    for (int i = 0; i < 8; i++)
      step(mk(0, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 0, 1, 0, 1, 28'(i + 1), 0),
           1'b1, $sformatf("ovf_drain%0d", i));
    step(mk(0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 1, 0, 0, 0, 0), 1'b1, "ovf_empty");

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int r;
      rv = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rv.rst = ($urandom_range(0, 199) == 0);
      rv.clr = ($urandom_range(0, 49) == 0);
      rv.sv  = $urandom_range(0, 1) == 1;
      rv.sp  = 2'($urandom_range(0, 3));
      rv.sd  = IW'($urandom);
      r = $urandom_range(0, 9);
      rv.req = (r < 4) ? 4'(1 << r) : (r < 7) ? 4'b0000 : 4'($urandom);
      r = $urandom_range(0, 9);
      rv.oe  = (r < 3) ? 4'(1 << r) : (r < 7) ? 4'b0000 : 4'($urandom);
      rv.io  = OW'($urandom);
      rv.mr  = $urandom_range(0, 2) == 0;
      step(rv, 1'b0, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
